// File: rtl/exu_muldiv_pkg.sv
// Shared operation and state codes for the exu_muldiv multiply/divide unit.
package exu_muldiv_pkg;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'b00,
    MD_ST_MUL  = 2'b01,
    MD_ST_DIV  = 2'b10,
    MD_ST_DONE = 2'b11
  } md_state_e;

  function automatic logic md_op_is_div(input logic [1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic md_op_is_signed(input logic [1:0] op);
    return !((op == MD_OP_MULTU) || (op == MD_OP_DIVU));
  endfunction

  function automatic logic md_op_is_mul(input logic [1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
  endfunction

endpackage

// File: rtl/exu_muldiv_if.sv
// Request/result bundle between the EXU issue logic and the multiply/divide unit.
interface exu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] srca_i;
  logic [WIDTH-1:0] srcb_i;
  logic             flush_i;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] wHiData;
  logic [WIDTH-1:0] wLoData;
  logic             whi;
  logic             wlo;

  modport master (
    output in_valid, op_i, srca_i, srcb_i, flush_i,
    input  in_ready, busy, done, wHiData, wLoData, whi, wlo
  );

  modport slave (
    input  in_valid, op_i, srca_i, srcb_i, flush_i,
    output in_ready, busy, done, wHiData, wLoData, whi, wlo
  );
endinterface

// File: rtl/exu_muldiv_step.sv
// One radix-2 iteration on the {hi, lo} accumulator: shift-add for multiply,
// restoring subtract for divide (hi holds the partial remainder, lo the quotient).
module exu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Partial remainder stays below the divisor, so the diff MSB is a clean borrow flag.
  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
    w_shift = {i_hi, i_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_b};
    o_hi    = {WIDTH{1'b0}};
    o_lo    = {WIDTH{1'b0}};
    if (i_is_div) begin
      if (!w_diff[WIDTH]) begin
        o_hi = w_diff[WIDTH-1:0];
        o_lo = {i_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_hi = w_shift[WIDTH-1:0];
        o_lo = {i_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/exu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing one HI/LO write pulse per operation.
// Build option FAST_MUL_EN: single-cycle multiply; divides remain iterative.
module exu_muldiv
  import exu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  exu_muldiv_if.slave bus
);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_whi;
  logic             r_wlo;
  logic [WIDTH-1:0] r_hi_data;
  logic [WIDTH-1:0] r_lo_data;

  logic               w_accept;
  logic               w_op_div;
  logic               w_op_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic [2*WIDTH-1:0] w_prod;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign bus.in_ready = (r_state == MD_ST_IDLE) && !rst;
  assign bus.busy     = (r_state != MD_ST_IDLE);
  assign bus.done     = r_done;
  assign bus.whi      = r_whi;
  assign bus.wlo      = r_wlo;
  assign bus.wHiData  = r_hi_data;
  assign bus.wLoData  = r_lo_data;

  exu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_b      (r_b),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // Operand decode into magnitudes, and sign fix-up of the final iteration's result.
  always_comb begin
    w_op_div    = md_op_is_div(bus.op_i);
    w_op_signed = md_op_is_signed(bus.op_i);
    w_a_neg     = w_op_signed && bus.srca_i[WIDTH-1];
    w_b_neg     = w_op_signed && bus.srcb_i[WIDTH-1];
    w_a_mag     = w_a_neg ? neg_w(bus.srca_i) : bus.srca_i;
    w_b_mag     = w_b_neg ? neg_w(bus.srcb_i) : bus.srcb_i;
    w_div_zero  = w_op_div && (bus.srcb_i == {WIDTH{1'b0}});
    w_accept    = bus.in_valid && bus.in_ready && !bus.flush_i;
    w_prod      = {2*WIDTH{1'b0}};
    if (r_is_div) begin
      w_res_hi = r_neg_rem ? neg_w(w_step_hi) : w_step_hi;
      w_res_lo = r_neg_res ? neg_w(w_step_lo) : w_step_lo;
    end else begin
      w_prod   = r_neg_res ? neg_2w({w_step_hi, w_step_lo}) : {w_step_hi, w_step_lo};
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
  end

`ifdef FAST_MUL_EN
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_fast_prod;

  // Sign- or zero-extend to 2W so a truncated 2W product is exact for both flavours.
  always_comb begin
    w_ext_a     = {{WIDTH{w_a_neg}}, bus.srca_i};
    w_ext_b     = {{WIDTH{w_b_neg}}, bus.srcb_i};
    w_fast_prod = w_ext_a * w_ext_b;
  end
`endif

  // Control FSM, iteration counter, datapath registers and registered write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= MD_ST_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b       <= {WIDTH{1'b0}};
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
      r_done    <= 1'b0;
      r_whi     <= 1'b0;
      r_wlo     <= 1'b0;
      r_hi_data <= {WIDTH{1'b0}};
      r_lo_data <= {WIDTH{1'b0}};
    end else begin
      r_done    <= 1'b0;
      r_whi     <= 1'b0;
      r_wlo     <= 1'b0;
      r_hi_data <= {WIDTH{1'b0}};
      r_lo_data <= {WIDTH{1'b0}};
      case (r_state)
        MD_ST_IDLE: begin
          if (w_accept) begin
            r_is_div  <= w_op_div;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= {CNT_W{1'b0}};
            r_hi      <= {WIDTH{1'b0}};
            r_lo      <= w_op_div ? w_a_mag : w_b_mag;
            r_b       <= w_op_div ? w_b_mag : w_a_mag;
            if (w_div_zero) begin
              // HI/LO stay untouched; the data lines only report the fault pattern.
              r_state   <= MD_ST_DONE;
              r_done    <= 1'b1;
              r_hi_data <= bus.srca_i;
              r_lo_data <= {WIDTH{1'b1}};
`ifdef FAST_MUL_EN
            end else if (md_op_is_mul(bus.op_i)) begin
              r_state   <= MD_ST_DONE;
              r_done    <= 1'b1;
              r_whi     <= 1'b1;
              r_wlo     <= 1'b1;
              r_hi_data <= w_fast_prod[2*WIDTH-1:WIDTH];
              r_lo_data <= w_fast_prod[WIDTH-1:0];
`endif
            end else begin
              r_state <= w_op_div ? MD_ST_DIV : MD_ST_MUL;
            end
          end
        end
        MD_ST_MUL, MD_ST_DIV: begin
          if (bus.flush_i) begin
            r_state <= MD_ST_IDLE;
          end else begin
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_cnt == LP_LAST) begin
              r_state   <= MD_ST_DONE;
              r_done    <= 1'b1;
              r_whi     <= 1'b1;
              r_wlo     <= 1'b1;
              r_hi_data <= w_res_hi;
              r_lo_data <= w_res_lo;
            end
          end
        end
        MD_ST_DONE: r_state <= MD_ST_IDLE;
        default:    r_state <= MD_ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exu_muldiv.sv
// Self-checking bench for exu_muldiv: arithmetic/timing model checked every cycle
// plus directed vectors with hand-computed results.
module tb_exu_muldiv;
  localparam int W = 32;
`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exu_muldiv_if #(.WIDTH(W)) bus ();
  exu_muldiv #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc   = 0;

  bit         m_active  = 1'b0;
  int         m_done_at = 0;
  logic       m_we      = 1'b0;
  logic [W-1:0] m_hi    = '0;
  logic [W-1:0] m_lo    = '0;

  // Result of an operation from plain integer arithmetic: {write_enable, hi, lo}.
  function automatic logic [2*W:0] model_res(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p = 64'd0; q = 64'd0; r = 64'd0;
    if (op[1] && b == 32'd0) return {1'b0, a, 32'hFFFF_FFFF};
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      2'b10: begin q = sa / sb; r = sa % sb; end
      default: begin q = ua / ub; r = ua % ub; end
    endcase
    if (op[1]) return {1'b1, r[31:0], q[31:0]};
    return {1'b1, p};
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] b);
    if (!op[1]) return MUL_LAT;
    return (b == 32'd0) ? 1 : DIV_LAT;
  endfunction

  // Model: idle/active with a known completion cycle; one idle cycle after each done.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (bus.flush_i || (cyc + 1 > m_done_at)) m_active <= 1'b0;
    end else if (bus.in_valid && !bus.flush_i) begin
      m_active  <= 1'b1;
      m_done_at <= cyc + model_lat(bus.op_i, bus.srcb_i);
      {m_we, m_hi, m_lo} <= model_res(bus.op_i, bus.srca_i, bus.srcb_i);
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk1("m_busy", bus.busy, m_active);
      chk1("m_ready", bus.in_ready, !m_active && !rst);
      chk1("m_done", bus.done, m_active && (cyc == m_done_at));
      chk1("m_whi", bus.whi, m_active && (cyc == m_done_at) && m_we);
      chk1("m_wlo", bus.wlo, m_active && (cyc == m_done_at) && m_we);
      chk32("m_hi", bus.wHiData, (m_active && cyc == m_done_at) ? m_hi : 32'd0);
      chk32("m_lo", bus.wLoData, (m_active && cyc == m_done_at) ? m_lo : 32'd0);
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_i = op; bus.srca_i = a; bus.srcb_i = b; bus.in_valid = 1'b1;
    nxt();
    acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic ewe, input int elat);
    bit seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      if (k > 0) nxt();
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        chk32({nm, "_lat"}, 32'(cyc - acc + 1), 32'(elat));
        chk32({nm, "_hi"}, bus.wHiData, eh);
        chk32({nm, "_lo"}, bus.wLoData, el);
        chk1({nm, "_whi"}, bus.whi, ewe);
        chk1({nm, "_wlo"}, bus.wlo, ewe);
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout cycle=%0d got=no_done want=done", nm, cyc);
    end
  endtask

  task automatic run(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                     input logic ewe, input int elat);
    issue(op, a, b);
    wait_done(nm, eh, el, ewe, elat);
    nxt();
  endtask

  typedef struct { logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b; } vec_t;
  vec_t vecs[6] = '{
    '{2'b00, 32'h8000_0000, 32'h8000_0000},
    '{2'b01, 32'h1234_5678, 32'h9ABC_DEF0},
    '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF},
    '{2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFE},
    '{2'b10, 32'h0000_0007, 32'hFFFF_FFFD},
    '{2'b11, 32'h0000_0005, 32'h0000_0009}
  };

  initial begin
    int n;
    logic [2*W:0] r;
    bus.in_valid = 1'b0; bus.op_i = 2'b00; bus.srca_i = '0; bus.srcb_i = '0; bus.flush_i = 1'b0;
    repeat (3) nxt();
    chk1("rst_ready", bus.in_ready, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk32("rst_lo", bus.wLoData, 32'd0);
    rst = 1'b0;
    nxt();
    chk1("ready_after_rst", bus.in_ready, 1'b1);

    run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, MUL_LAT);
    run("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, MUL_LAT);
    run("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, DIV_LAT);
    run("div_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1, DIV_LAT);
    run("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0, 1);
    run("div_zero", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1);

    // Flush at cycle +10 of a DIVU: no write-back, back to ready one cycle later.
    issue(2'b11, 32'd100, 32'd7);
    n = 0;
    for (int k = 0; k < 9; k++) begin
      nxt();
      if (bus.done === 1'b1) n++;
    end
    bus.flush_i = 1'b1;
    nxt();
    bus.flush_i = 1'b0;
    chk32("flush_no_done", 32'(n), 32'd0);
    chk1("flush_ready", bus.in_ready, 1'b1);
    chk1("flush_busy", bus.busy, 1'b0);
    run("divu_after_flush", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, DIV_LAT);

    // Flush together with a request in IDLE: nothing is accepted.
    bus.op_i = 2'b11; bus.srca_i = 32'd50; bus.srcb_i = 32'd5;
    bus.in_valid = 1'b1; bus.flush_i = 1'b1;
    nxt();
    bus.in_valid = 1'b0; bus.flush_i = 1'b0;
    chk1("flush_idle_busy", bus.busy, 1'b0);

    // Flush during the done cycle: that pulse still stands.
    issue(2'b11, 32'd9, 32'd0);
    chk1("flush_done_pulse", bus.done, 1'b1);
    bus.flush_i = 1'b1;
    nxt();
    bus.flush_i = 1'b0;
    chk1("flush_done_after", bus.done, 1'b0);
    chk1("flush_done_busy", bus.busy, 1'b0);

    // Synchronous reset in the middle of a divide.
    issue(2'b10, 32'd1000, 32'd3);
    repeat (4) nxt();
    rst = 1'b1;
    nxt();
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_ready", bus.in_ready, 1'b0);
    chk1("midrst_done", bus.done, 1'b0);
    chk32("midrst_hi", bus.wHiData, 32'd0);
    rst = 1'b0;
    nxt();
    chk1("midrst_ready_after", bus.in_ready, 1'b1);

    // in_valid held high: one completion in the first 40 cycles, re-accept after the idle cycle.
    bus.op_i = 2'b11; bus.srca_i = 32'd50; bus.srcb_i = 32'd5; bus.in_valid = 1'b1;
    nxt();
    acc = cyc;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) nxt();
      if (bus.done === 1'b1) n++;
    end
    bus.in_valid = 1'b0;
    chk32("held_one_done", 32'(n), 32'd1);
    acc = acc + 34;
    wait_done("held_second", 32'd0, 32'd10, 1'b1, DIV_LAT);
    nxt();

    foreach (vecs[i]) begin
      r = model_res(vecs[i].op, vecs[i].a, vecs[i].b);
      run("vec", vecs[i].op, vecs[i].a, vecs[i].b, r[2*W-1:W], r[W-1:0], r[2*W],
          model_lat(vecs[i].op, vecs[i].b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
